// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter: FSM states, requester index, default line terminator.
package uart_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  typedef logic req_idx_t;

  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

endpackage

// File: rtl/uart_arb_rr2.sv
// Combinational 2-way round-robin picker: on contention the requester that did not own last wins.
module uart_arb_rr2
  import uart_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   last_owner,
  output req_idx_t   grant,
  output logic       any
);

  always_comb begin
    any = |valid;
    if (&valid) begin
      grant = ~last_owner;
    end else begin
      grant = valid[1];
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Line-locked 2-requester byte arbiter into the UART TX FIFO; 1-cycle grant, combinational accept gated by fifo_full.
// UART_ARB_LOCK_EN enables per-line ownership (EOL/MAX_BURST/IDLE_TIMEOUT release); without it ownership drops after every byte.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 255,
  parameter logic [7:0] EOL_CHAR     = EOL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wr_data,
  input  logic       fifo_full,
  output logic       owner,
  output logic       locked
);

`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e     state_q, state_d;
  req_idx_t       owner_q, owner_d;
  req_idx_t       last_owner_q, last_owner_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [IW-1:0]  idle_q, idle_d;

  req_idx_t       grant;
  logic           any_valid;
  logic           own_valid;
  logic [7:0]     own_data;
  logic [BW-1:0]  burst_inc;
  logic [IW-1:0]  idle_inc;

  uart_arb_rr2 u_rr2 (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (last_owner_q),
    .grant      (grant),
    .any        (any_valid)
  );

  assign own_valid = owner_q ? req1_valid : req0_valid;
  assign own_data  = owner_q ? req1_data  : req0_data;
  assign burst_inc = burst_q + BW'(1);
  assign idle_inc  = idle_q + IW'(1);
  assign owner     = owner_q;
  assign locked    = (state_q == ARB_OWN);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    idle_d       = idle_q;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          owner_d = grant;
          burst_d = '0;
          idle_d  = '0;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (own_valid && !fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = own_data;
          req0_ready   = ~owner_q;
          req1_ready   = owner_q;
          burst_d      = burst_inc;
        end
        // A full-FIFO stall keeps valid high, so it never advances the idle count.
        idle_d = own_valid ? '0 : idle_inc;
        if ((own_valid && !fifo_full &&
             (!LOCK_EN || own_data == EOL_CHAR || burst_inc == BW'(MAX_BURST))) ||
            (!own_valid && idle_inc == IW'(IDLE_TIMEOUT))) begin
          state_d      = ARB_IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      burst_q      <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      idle_q       <= idle_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized + directed bench for uart_tx_arb against a per-cycle behavioural model of the arbitration rules.
module tb_uart_tx_arb;

  localparam int         MAXB = 64;
  localparam int         ITO  = 255;
  localparam logic [7:0] EOL  = 8'h0A;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_full = 1'b0;
  logic       owner, locked;

  always #5 clk = ~clk;

  uart_tx_arb #(.MAX_BURST(MAXB), .IDLE_TIMEOUT(ITO), .EOL_CHAR(EOL)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .owner(owner), .locked(locked)
  );

  int n_chk = 0;
  int n_err = 0;
  int ncyc  = 0;

  logic [7:0] q0[$], q1[$];
  int         g0 = 0, g1 = 0;
  bit         acc0 = 0, acc1 = 0;
  bit         rand_mode = 0;
  bit         full_force = 0;
  logic [7:0] cap[$];
  int         cap_t[$];

  bit m_locked;
  int m_owner, m_last, m_burst, m_idle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Reference: a line owner keeps the path until EOL, MAX_BURST bytes, or ITO consecutive empty cycles.
  always @(negedge clk) begin : cmp
    bit         ov, acc, rel;
    logic [7:0] od;
    ncyc++;
    if (rst) begin
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_owner", owner, 0);
      chk("rst_locked", locked, 0);
      m_locked = 0; m_owner = 0; m_last = 1; m_burst = 0; m_idle = 0;
      acc0 = 0; acc1 = 0;
    end else begin
      if (!m_locked) begin
        chk("idle_wr_en", fifo_wr_en, 0);
        chk("idle_wr_data", fifo_wr_data, 0);
        chk("idle_ready0", req0_ready, 0);
        chk("idle_ready1", req1_ready, 0);
        chk("idle_owner", owner, m_owner);
        chk("idle_locked", locked, 0);
        if (req0_valid || req1_valid) begin
          m_owner  = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
          m_locked = 1; m_burst = 0; m_idle = 0;
        end
      end else begin
        ov  = (m_owner == 1) ? req1_valid : req0_valid;
        od  = (m_owner == 1) ? req1_data  : req0_data;
        acc = ov && !fifo_full;
        chk("own_wr_en", fifo_wr_en, acc);
        chk("own_wr_data", fifo_wr_data, acc ? od : 8'h00);
        chk("own_ready0", req0_ready, acc && m_owner == 0);
        chk("own_ready1", req1_ready, acc && m_owner == 1);
        chk("own_owner", owner, m_owner);
        chk("own_locked", locked, 1);
        rel = 0;
        if (acc) begin
          m_burst++;
          if (!LOCK || od == EOL || m_burst == MAXB) rel = 1;
        end
        if (ov) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == ITO) rel = 1;
        end
        if (rel) begin m_locked = 0; m_last = m_owner; end
      end
      if (fifo_wr_en === 1'b1) begin cap.push_back(fifo_wr_data); cap_t.push_back(ncyc); end
      acc0 = (req0_ready === 1'b1);
      acc1 = (req1_ready === 1'b1);
    end
  end

  function automatic int next_gap();
    int r;
    if (!rand_mode) return 0;
    r = $urandom_range(0, 99);
    if (r < 65) return 0;
    if (r < 97) return $urandom_range(1, 6);
    return $urandom_range(200, 300);
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    return ($urandom_range(0, 5) == 0) ? EOL : b;
  endfunction

  task automatic step();
    @(posedge clk);
    if (acc0 && q0.size() > 0) begin void'(q0.pop_front()); g0 = next_gap(); end
    else if (g0 > 0) g0--;
    if (acc1 && q1.size() > 0) begin void'(q1.pop_front()); g1 = next_gap(); end
    else if (g1 > 0) g1--;
    #1;
    req0_valid = (q0.size() > 0 && g0 == 0);
    req0_data  = req0_valid ? q0[0] : 8'h00;
    req1_valid = (q1.size() > 0 && g1 == 0);
    req1_data  = req1_valid ? q1[0] : 8'h00;
    fifo_full  = rand_mode ? ($urandom_range(0, 4) == 0) : full_force;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    g0 = 0; g1 = 0; full_force = 0; rand_mode = 0;
    repeat (3) step();
    rst = 1'b0;
    cap.delete(); cap_t.delete();
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin step(); n++; end
    chk({nm, "_drained"}, q0.size() + q1.size(), 0);
    repeat (2) step();
  endtask

  task automatic wait_cap(input string nm, input int cnt, input int budget);
    int n = 0;
    while (cap.size() < cnt && n < budget) begin step(); n++; end
    chk({nm, "_first_write"}, cap.size(), cnt);
  endtask

  initial begin
    int t0, n;

    // Single line from req0, then contention with last_owner = 0.
    do_reset();
    q0 = '{8'h41, 8'h42, 8'h0A};
    step();
    t0 = ncyc + 1;
    drain("t1", 50);
    chk("t1_count", cap.size(), 3);
    chk("t1_b0", cap[0], 8'h41);
    chk("t1_b1", cap[1], 8'h42);
    chk("t1_b2", cap[2], 8'h0A);
    chk("t1_latency", cap_t[0] - t0, 1);
    chk("t1_spacing", cap_t[2] - cap_t[1], LOCK ? 1 : 2);
    chk("t1_unlocked", locked, 0);
    q0 = '{8'h30, 8'h0A};
    q1 = '{8'h31, 8'h0A};
    drain("t1b", 50);
    chk("t1b_req1_first", cap[3], 8'h31);

    // Simultaneous lines after reset: req0 first.
    do_reset();
    q0 = '{8'h58, 8'h0A};
    q1 = '{8'h59, 8'h0A};
    drain("t2", 50);
    chk("t2_count", cap.size(), 4);
    chk("t2_b0", cap[0], 8'h58);
    chk("t2_b1", cap[1], LOCK ? 8'h0A : 8'h59);
    chk("t2_b2", cap[2], LOCK ? 8'h59 : 8'h0A);
    chk("t2_b3", cap[3], 8'h0A);

    // fifo_full held 20 cycles after the first byte.
    do_reset();
    q0 = '{8'h4C, 8'h4D, 8'h4E, 8'h0A};
    wait_cap("t5", 1, 50);
    full_force = 1; fifo_full = 1'b1;
    repeat (19) step();
    full_force = 0;
    drain("t5", 50);
    chk("t5_count", cap.size(), 4);
    chk("t5_b1", cap[1], 8'h4D);
    chk("t5_resume", cap_t[1] - cap_t[0], 21);
    chk("t5_spacing", cap_t[2] - cap_t[1], LOCK ? 1 : 2);

    // Asynchronous reset while a byte is being offered.
    do_reset();
    q0 = '{8'h31, 8'h32, 8'h33, 8'h34};
    n = 0;
    while (!(locked === 1'b1 && req0_valid === 1'b1) && n < 20) begin step(); n++; end
    chk("trst_owned", locked, 1);
    #1 rst = 1'b1;
    #1;
    chk("trst_wr_en", fifo_wr_en, 0);
    chk("trst_ready0", req0_ready, 0);
    chk("trst_locked", locked, 0);
    q0.delete();

`ifdef UART_ARB_LOCK_EN
    // req1 streams 70 bytes without EOL while req0 waits.
    do_reset();
    for (int i = 0; i < 70; i++) q1.push_back(8'(8'h80 + i));
    repeat (3) step();
    q0 = '{8'h5A, 8'h0A};
    drain("t3", 400);
    chk("t3_count", cap.size(), 72);
    chk("t3_b63", cap[63], 8'hBF);
    chk("t3_b64", cap[64], 8'h5A);
    chk("t3_b65", cap[65], 8'h0A);
    chk("t3_b66", cap[66], 8'hC0);
    chk("t3_b71", cap[71], 8'hC5);
    chk("t3_regrant_gap", cap_t[64] - cap_t[63], 2);

    // Owner goes quiet after one byte; idle timeout hands over to req1.
    do_reset();
    q0 = '{8'h51};
    wait_cap("t4", 1, 50);
    q1 = '{8'h52, 8'h0A};
    drain("t4", 600);
    chk("t4_count", cap.size(), 3);
    chk("t4_b1", cap[1], 8'h52);
    chk("t4_timeout", cap_t[1] - cap_t[0], 257);
`else
    // Byte-level round robin with both requesters always valid.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(8'(8'h20 + i));
      q1.push_back(8'(8'h60 + i));
    end
    drain("t6", 100);
    chk("t6_count", cap.size(), 20);
    for (int i = 0; i < 20; i++)
      chk("t6_byte", cap[i], (i % 2 == 1) ? 8'(8'h60 + i / 2) : 8'(8'h20 + i / 2));
    for (int i = 1; i < 20; i++)
      chk("t6_spacing", cap_t[i] - cap_t[i - 1], 2);
`endif

    // Random traffic, gaps, and FIFO backpressure.
    do_reset();
    rand_mode = 1;
    repeat (4000) begin
      if (q0.size() < 4 && $urandom_range(0, 7) == 0) q0.push_back(rand_byte());
      if (q1.size() < 4 && $urandom_range(0, 7) == 0) q1.push_back(rand_byte());
      step();
    end
    rand_mode = 0;
    drain("rand", 3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
